decode_stage: RTL
=================

Name: decode_stage

Overview:
- RV32I decode stage sitting directly upstream of the ALU.
- Accepts a fetched instruction and its PC over a valid/ready handshake and decodes it to a cuOPType.
- Reads operands from an internal 32x32 register file that has a writeback port.
- Presents registered aluOP/inputA/inputB plus writeback metadata to the execute stage through a one-entry output register with backpressure.

Parameters:
- RESET_PC_OUT, 32'h0000_0000, reset value of pc_out.
- NUM_REGS, 32, register count; x0 is hardwired to zero.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- nRst  in  1  asynchronous, active-low reset.
- instr_valid  in  1  upstream has an instruction.
- instr_ready  out  1  decode can accept this cycle.
- instr  in  32  raw RV32I instruction word.
- pc  in  32  PC of instr.
- flush  in  1  discard the held output (branch redirect).
- wb_en  in  1  register-file write enable.
- wb_rd  in  5  write index.
- wb_data  in  32  write data.
- out_valid  out  1  decoded entry held for execute.
- out_ready  in  1  execute consumes the entry this cycle.
- aluOP  out  6 (cuOPType)  decoded operation.
- inputA  out  32  ALU operand A.
- inputB  out  32  ALU operand B.
- imm  out  32  sign-extended immediate (store/branch offset).
- store_data  out  32  rs2 value (for stores).
- rd  out  5  destination register.
- reg_write  out  1  instruction writes rd.
- pc_out  out  32  PC of the held entry.
- illegal  out  1  held entry is undecodable.

Behaviour:
- Reset: all registered outputs go to 0, except pc_out = RESET_PC_OUT and aluOP = CU_ERROR. out_valid=0. All registers cleared to 0. Reset asserted mid-transfer drops the held entry with no partial state.
- FSM has two states, EMPTY (out_valid=0) and FULL (out_valid=1).
- instr_ready = !out_valid || out_ready (combinational).
- Capture when instr_valid && instr_ready: outputs update on that edge, giving 1-cycle latency.
- EMPTY + capture -> FULL.
- FULL + out_ready and no capture -> EMPTY.
- FULL + out_ready + capture -> FULL with the new entry (back-to-back, full throughput).
- FULL + !out_ready: every output holds stable.
- flush has priority over everything: next state is EMPTY, and any capture in that cycle is discarded.
- Register file:
  - Write on the edge when wb_en && wb_rd != 0; writes to x0 are ignored and x0 always reads 0.
  - Same-cycle bypass: if wb_en && wb_rd != 0 && wb_rd equals rs1 or rs2 of the instruction being captured, wb_data is used for that operand.
  - Writeback proceeds regardless of FSM state or flush.
- Operand selection:
  - R-type: A=rs1, B=rs2.
  - OP-IMM and loads: A=rs1, B=I-imm.
  - Shift-immediates: B = zero-extended shamt (instr[24:20]).
  - Stores: A=rs1, B=S-imm, store_data=rs2.
  - Branches: A=rs1, B=rs2, imm=B-imm.
  - LUI: A=0, B=U-imm.
  - AUIPC: A=pc, B=U-imm.
  - JAL: A=pc, B=J-imm.
  - JALR: A=rs1, B=I-imm.
- reg_write is 1 for R, OP-IMM, load, LUI, AUIPC, JAL and JALR, and 0 for branch, store and illegal.
- Decode strictly on opcode, funct3 and funct7:
  - SLLI/SRLI require funct7=0000000; SRAI requires 0100000.
  - ADD/SUB and SRL/SRA are distinguished by funct7 bit 5.
  - CU_SLIU is never produced.
- Illegal conditions: unknown opcode, bad funct3/funct7, or instr[1:0] != 2'b11. Response: aluOP=CU_ERROR, illegal=1, reg_write=0, and the entry still flows through the handshake.
- All arithmetic is 32-bit wrap; no flags are produced in this stage.

Decomposition:
- Package cpu_pkg holds:
  - cuOPType, moved out of the top-level file.
  - Opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG).
  - Funct7 constants.
- Sub-module register_file: 2 read ports, 1 write port, x0 hardwired, asynchronous reset. The bypass mux stays in decode_stage.

Test Plan:
- Reset, then instr=0x00500093 (ADDI x1,x0,5) with out_ready=1 -> next cycle out_valid=1, aluOP=CU_ADDI, inputA=0, inputB=5, rd=1, reg_write=1.
- Write x1=10 and x2=15 via wb, then instr=0x002081B3 (ADD x3,x1,x2) -> aluOP=CU_ADD, inputA=10, inputB=15 (the ALU then gives 25).
- wb_en=1, wb_rd=5, wb_data=0xDEADBEEF in the same cycle as capturing 0xFFF28313 (ADDI x6,x5,-1) -> inputA=0xDEADBEEF, inputB=0xFFFFFFFF. Also wb_rd=0 with wb_data=7 -> later reads of x0 return 0.
- Backpressure:
  - Hold out_ready=0 with out_valid=1 -> instr_ready=0 and all outputs stable for 5 cycles.
  - Raise out_ready with instr_valid=1 -> the new entry is captured on the same edge, with no bubble.
- instr=0xFFFFFFFF -> aluOP=CU_ERROR, illegal=1, reg_write=0. Also 0x40001013 (SLLI with funct7=0100000) -> illegal=1.
- Assert flush while FULL and instr_valid=1 -> next cycle out_valid=0 and nothing captured. Deassert nRst mid-stream -> out_valid=0, and a register read returns 0 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU decode types: ALU operation codes, RV32I opcode map and funct7 patterns.
package cpu_pkg;

    typedef enum logic [5:0] {
        CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_SRA, CU_OR, CU_AND,
        CU_ADDI, CU_SLTI, CU_SLTIU, CU_XORI, CU_ORI, CU_ANDI, CU_SLLI, CU_SRLI, CU_SRAI,
        CU_SLIU,
        CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
        CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
        CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU,
        CU_SB, CU_SH, CU_SW,
        CU_ERROR = 6'h3F
    } cuOPType;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } dec_state_t;

endpackage

// File: rtl/register_file.sv
// Integer register file: two asynchronous read ports, one write port, x0 hardwired to zero.
module register_file #(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [4:0]  rd_addr_a_i,
    output logic [31:0] rd_data_a_o,
    input  logic [4:0]  rd_addr_b_i,
    output logic [31:0] rd_data_b_o,
    input  logic        wr_en_i,
    input  logic [4:0]  wr_addr_i,
    input  logic [31:0] wr_data_i
);

    logic [31:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i && (wr_addr_i != '0)) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_a_o = (rd_addr_a_i == '0) ? '0 : regs_q[rd_addr_a_i];
    assign rd_data_b_o = (rd_addr_b_i == '0) ? '0 : regs_q[rd_addr_b_i];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes a fetched instruction into an ALU operation and operands,
// held in a one-entry output register with valid/ready flow control.
module decode_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC_OUT = 32'h0000_0000,
    parameter int unsigned NUM_REGS     = 32
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output cuOPType     aluOP,
    output logic [31:0] inputA,
    output logic [31:0] inputB,
    output logic [31:0] imm,
    output logic [31:0] store_data,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic [31:0] pc_out,
    output logic        illegal
);

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2;
    logic [31:0] rf_rdata_a, rf_rdata_b, rs1_val, rs2_val;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, shamt;
    logic        wb_hit, capture, dec_legal;

    cuOPType     aluOP_d, aluOP_q;
    logic [31:0] inputA_d, inputA_q, inputB_d, inputB_q, imm_d, imm_q;
    logic [31:0] store_data_d, store_data_q, pc_q;
    logic [4:0]  rd_d, rd_q;
    logic        reg_write_d, reg_write_q, illegal_q;
    dec_state_t  state_q;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign i_imm = {{20{instr[31]}}, instr[31:20]};
    assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_imm = {instr[31:12], 12'h000};
    assign j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign shamt = {27'd0, instr[24:20]};

    register_file #(
        .NUM_REGS(NUM_REGS)
    ) u_register_file (
        .clk         (clk),
        .nRst        (nRst),
        .rd_addr_a_i (rs1),
        .rd_data_a_o (rf_rdata_a),
        .rd_addr_b_i (rs2),
        .rd_data_b_o (rf_rdata_b),
        .wr_en_i     (wb_en),
        .wr_addr_i   (wb_rd),
        .wr_data_i   (wb_data)
    );

    // A write landing on the capture edge must be visible to the instruction being decoded.
    assign wb_hit  = wb_en && (wb_rd != '0);
    assign rs1_val = (wb_hit && (wb_rd == rs1)) ? wb_data : rf_rdata_a;
    assign rs2_val = (wb_hit && (wb_rd == rs2)) ? wb_data : rf_rdata_b;

    always_comb begin
        aluOP_d     = CU_ERROR;
        inputA_d    = '0;
        inputB_d    = '0;
        imm_d       = '0;
        reg_write_d = 1'b0;
        dec_legal   = 1'b1;
        case (opcode)
            OP_LUI: begin
                aluOP_d = CU_LUI; inputB_d = u_imm; imm_d = u_imm; reg_write_d = 1'b1;
            end
            OP_AUIPC: begin
                aluOP_d = CU_AUIPC; inputA_d = pc; inputB_d = u_imm; imm_d = u_imm;
                reg_write_d = 1'b1;
            end
            OP_JAL: begin
                aluOP_d = CU_JAL; inputA_d = pc; inputB_d = j_imm; imm_d = j_imm;
                reg_write_d = 1'b1;
            end
            OP_JALR: begin
                aluOP_d = CU_JALR; inputA_d = rs1_val; inputB_d = i_imm; imm_d = i_imm;
                reg_write_d = 1'b1; dec_legal = (funct3 == 3'b000);
            end
            OP_BRANCH: begin
                inputA_d = rs1_val; inputB_d = rs2_val; imm_d = b_imm;
                case (funct3)
                    3'b000:  aluOP_d = CU_BEQ;
                    3'b001:  aluOP_d = CU_BNE;
                    3'b100:  aluOP_d = CU_BLT;
                    3'b101:  aluOP_d = CU_BGE;
                    3'b110:  aluOP_d = CU_BLTU;
                    3'b111:  aluOP_d = CU_BGEU;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                inputA_d = rs1_val; inputB_d = i_imm; imm_d = i_imm; reg_write_d = 1'b1;
                case (funct3)
                    3'b000:  aluOP_d = CU_LB;
                    3'b001:  aluOP_d = CU_LH;
                    3'b010:  aluOP_d = CU_LW;
                    3'b100:  aluOP_d = CU_LBU;
                    3'b101:  aluOP_d = CU_LHU;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                inputA_d = rs1_val; inputB_d = s_imm; imm_d = s_imm;
                case (funct3)
                    3'b000:  aluOP_d = CU_SB;
                    3'b001:  aluOP_d = CU_SH;
                    3'b010:  aluOP_d = CU_SW;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                inputA_d = rs1_val; inputB_d = i_imm; imm_d = i_imm; reg_write_d = 1'b1;
                case (funct3)
                    3'b000: aluOP_d = CU_ADDI;
                    3'b010: aluOP_d = CU_SLTI;
                    3'b011: aluOP_d = CU_SLTIU;
                    3'b100: aluOP_d = CU_XORI;
                    3'b110: aluOP_d = CU_ORI;
                    3'b111: aluOP_d = CU_ANDI;
                    3'b001: begin
                        aluOP_d = CU_SLLI; inputB_d = shamt; dec_legal = (funct7 == F7_BASE);
                    end
                    3'b101: begin
                        inputB_d = shamt;
                        if (funct7 == F7_BASE)     aluOP_d = CU_SRLI;
                        else if (funct7 == F7_ALT) aluOP_d = CU_SRAI;
                        else                       dec_legal = 1'b0;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_REG: begin
                inputA_d = rs1_val; inputB_d = rs2_val; reg_write_d = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  aluOP_d = CU_ADD;
                        3'b001:  aluOP_d = CU_SLL;
                        3'b010:  aluOP_d = CU_SLT;
                        3'b011:  aluOP_d = CU_SLTU;
                        3'b100:  aluOP_d = CU_XOR;
                        3'b101:  aluOP_d = CU_SRL;
                        3'b110:  aluOP_d = CU_OR;
                        default: aluOP_d = CU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000:  aluOP_d = CU_SUB;
                        3'b101:  aluOP_d = CU_SRA;
                        default: dec_legal = 1'b0;
                    endcase
                end else begin
                    dec_legal = 1'b0;
                end
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            aluOP_d     = CU_ERROR;
            inputA_d    = '0;
            inputB_d    = '0;
            imm_d       = '0;
            reg_write_d = 1'b0;
        end
    end

    assign store_data_d = dec_legal ? rs2_val : '0;
    assign rd_d         = reg_write_d ? instr[11:7] : '0;

    assign out_valid   = (state_q == ST_FULL);
    assign instr_ready = !out_valid || out_ready;
    assign capture     = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q      <= ST_EMPTY;
            aluOP_q      <= CU_ERROR;
            inputA_q     <= '0;
            inputB_q     <= '0;
            imm_q        <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            illegal_q    <= 1'b0;
            pc_q         <= RESET_PC_OUT;
        end else if (flush) begin
            state_q <= ST_EMPTY;
        end else begin
            if (capture) begin
                aluOP_q      <= aluOP_d;
                inputA_q     <= inputA_d;
                inputB_q     <= inputB_d;
                imm_q        <= imm_d;
                store_data_q <= store_data_d;
                rd_q         <= rd_d;
                reg_write_q  <= reg_write_d;
                illegal_q    <= !dec_legal;
                pc_q         <= pc;
            end
            case (state_q)
                ST_EMPTY: if (capture) state_q <= ST_FULL;
                ST_FULL:  if (!capture && out_ready) state_q <= ST_EMPTY;
                default:  state_q <= ST_EMPTY;
            endcase
        end
    end

    assign aluOP      = aluOP_q;
    assign inputA     = inputA_q;
    assign inputB     = inputB_q;
    assign imm        = imm_q;
    assign store_data = store_data_q;
    assign rd         = rd_q;
    assign reg_write  = reg_write_q;
    assign pc_out     = pc_q;
    assign illegal    = illegal_q;

endmodule
